// File: rtl/crtc_timing.sv
// crtc_timing: 6845-style programmable CRT controller timing core.
//
// Generates horizontal/vertical sync, display enable, refresh memory address,
// raster address and cursor from a CPU-writable register file. All timing
// advances on clk edges where char_ce is high.
//
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   char_ce       character clock enable
//   reg_we        register write strobe (sampled every clk)
//   reg_addr      register index 0..17
//   reg_wdata     register write data
//   reg_rdata     combinational read data (only R14/R15 are readable)
//   h_sync        horizontal sync, active-high
//   v_sync        vertical sync, active-high
//   de            display enable
//   ma            refresh memory address
//   ra            raster address within the character row
//   cursor        cursor active for this character
//   frame_start   one-character pulse at h=0, row=0, raster=0
//
// Outputs are registered: on each char_ce edge they capture the values of the
// character the counters currently point at, while the counters advance.
module crtc_timing #(
  parameter int unsigned H_WIDTH  = 8,
  parameter int unsigned V_WIDTH  = 7,
  parameter int unsigned RA_WIDTH = 5,
  parameter int unsigned MA_WIDTH = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                char_ce,
  input  logic                reg_we,
  input  logic [4:0]          reg_addr,
  input  logic [7:0]          reg_wdata,
  output logic [7:0]          reg_rdata,
  output logic                h_sync,
  output logic                v_sync,
  output logic                de,
  output logic [MA_WIDTH-1:0] ma,
  output logic [RA_WIDTH-1:0] ra,
  output logic                cursor,
  output logic                frame_start
);

  typedef enum logic [1:0] {StActive, StBlank, StAdjust} vstate_e;

  localparam logic [7:0] RegDefault [16] = '{
    8'd63, 8'd40, 8'd48, 8'h15, 8'd32, 8'd0, 8'd25, 8'd28,
    8'd0,  8'd7,  8'h20, 8'd0,  8'h10, 8'd0, 8'd0,  8'd0
  };

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [7:0] regs_q [16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= RegDefault;
    end else if (reg_we && !reg_addr[4] && (reg_addr[3:0] != 4'd8)) begin
      regs_q[reg_addr[3:0]] <= reg_wdata;
    end
  end

  always_comb begin
    reg_rdata = '0;
    if (reg_addr == 5'd14) begin
      reg_rdata = regs_q[14];
    end else if (reg_addr == 5'd15) begin
      reg_rdata = regs_q[15];
    end
  end

  // Decoded register fields
  logic [H_WIDTH-1:0]  r_htot, r_hdisp, r_hspos;
  logic [V_WIDTH-1:0]  r_vtot, r_vdisp, r_vspos;
  logic [RA_WIDTH-1:0] r_maxra;
  logic [4:0]          r_adj;
  logic [3:0]          hs_width_m1, vs_width_m1;
  logic [MA_WIDTH-1:0] start_addr, cur_addr;

  assign r_htot      = H_WIDTH'(regs_q[0]);
  assign r_hdisp     = H_WIDTH'(regs_q[1]);
  assign r_hspos     = H_WIDTH'(regs_q[2]);
  // Width fields of 0 mean 16; subtracting 1 in 4 bits wraps 0 to 15.
  assign hs_width_m1 = regs_q[3][3:0] - 4'd1;
  assign vs_width_m1 = regs_q[3][7:4] - 4'd1;
  assign r_vtot      = V_WIDTH'(regs_q[4]);
  assign r_adj       = regs_q[5][4:0];
  assign r_vdisp     = V_WIDTH'(regs_q[6]);
  assign r_vspos     = V_WIDTH'(regs_q[7]);
  assign r_maxra     = RA_WIDTH'(regs_q[9]);
  assign start_addr  = MA_WIDTH'({regs_q[12], regs_q[13]});
  assign cur_addr    = MA_WIDTH'({regs_q[14], regs_q[15]});

  logic unused_bits;
  assign unused_bits = ^{regs_q[5][7:5], regs_q[8], regs_q[10][7], regs_q[11][7:5]};

  // ---------------------------------------------------------------------------
  // Counter state
  // ---------------------------------------------------------------------------
  logic [H_WIDTH-1:0]  h_cnt_q;
  logic [V_WIDTH-1:0]  row_q;
  logic [RA_WIDTH-1:0] ra_q;
  vstate_e             state_q;
  logic [MA_WIDTH-1:0] ma_q, row_start_q;
  logic [3:0]          hs_rem_q, vs_rem_q;
  logic [5:0]          frame_cnt_q;

  // ---------------------------------------------------------------------------
  // Next-line computation (applied only at end-of-line)
  // ---------------------------------------------------------------------------
  logic                h_end, ra_last, row_last, adj_done, frame_wrap, adj_d;
  logic [V_WIDTH-1:0]  row_d;
  logic [RA_WIDTH-1:0] ra_d;
  vstate_e             state_d;

  // The all-ones terms keep the counters from running away when a total
  // register is rewritten below the current count.
  assign h_end    = (h_cnt_q == r_htot) || (h_cnt_q == '1);
  assign ra_last  = (ra_q == r_maxra) || (ra_q == '1);
  assign row_last = (row_q == r_vtot) || (row_q == '1);
  assign adj_done = (32'(ra_q) + 32'd1) >= 32'(r_adj);

  always_comb begin
    frame_wrap = 1'b0;
    adj_d      = 1'b0;
    row_d      = row_q;
    ra_d       = ra_q + 1'b1;
    if (state_q == StAdjust) begin
      adj_d = 1'b1;
      if (adj_done) begin
        frame_wrap = 1'b1;
      end
    end else if (ra_last) begin
      ra_d = '0;
      if (row_last) begin
        if (r_adj == 5'd0) begin
          frame_wrap = 1'b1;
        end else begin
          adj_d = 1'b1;
        end
      end else begin
        row_d = row_q + 1'b1;
      end
    end
    if (frame_wrap) begin
      row_d = '0;
      ra_d  = '0;
      adj_d = 1'b0;
    end
    if (adj_d) begin
      state_d = StAdjust;
    end else if (row_d < r_vdisp) begin
      state_d = StActive;
    end else begin
      state_d = StBlank;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-character output terms for the current counter values
  // ---------------------------------------------------------------------------
  logic                hs_start, vs_start, de_c, hs_c, vs_c, fs_c, cur_c;
  logic                ra_in_cursor, blink_on, latch_row_start;
  logic [MA_WIDTH-1:0] row_start_d;

  assign hs_start = (h_cnt_q == r_hspos);
  assign vs_start = (row_q == r_vspos) && (ra_q == '0) && (state_q != StAdjust);
  assign hs_c     = hs_start || (hs_rem_q != 4'd0);
  assign vs_c     = vs_start || (vs_rem_q != 4'd0);
  assign de_c     = (h_cnt_q < r_hdisp) && (state_q == StActive);
  assign fs_c     = (h_cnt_q == '0) && (row_q == '0) && (ra_q == '0) && (state_q != StAdjust);

  assign ra_in_cursor = (32'(ra_q) >= 32'(regs_q[10][4:0])) &&
                        (32'(ra_q) <= 32'(regs_q[11][4:0]));

  always_comb begin
    blink_on = 1'b1;
    unique case (regs_q[10][6:5])
      2'b00: blink_on = 1'b1;
      2'b01: blink_on = 1'b0;
      2'b10: blink_on = ~frame_cnt_q[4];
      2'b11: blink_on = ~frame_cnt_q[5];
      default: blink_on = 1'b1;
    endcase
  end

  assign cur_c = de_c && (ma_q == cur_addr) && ra_in_cursor && blink_on;

  // The first undisplayed address of the last raster becomes the next row's base.
  assign latch_row_start = (h_cnt_q == r_hdisp) && ra_last && (state_q != StAdjust);
  assign row_start_d     = latch_row_start ? ma_q : row_start_q;

  // ---------------------------------------------------------------------------
  // Timing FSM, counters and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q     <= '0;
      row_q       <= '0;
      ra_q        <= '0;
      state_q     <= StActive;
      ma_q        <= MA_WIDTH'(16'h1000);
      row_start_q <= MA_WIDTH'(16'h1000);
      hs_rem_q    <= '0;
      vs_rem_q    <= '0;
      frame_cnt_q <= '0;
      h_sync      <= 1'b0;
      v_sync      <= 1'b0;
      de          <= 1'b0;
      ma          <= '0;
      ra          <= '0;
      cursor      <= 1'b0;
      frame_start <= 1'b0;
    end else if (char_ce) begin
      h_sync      <= hs_c;
      v_sync      <= vs_c;
      de          <= de_c;
      ma          <= ma_q;
      ra          <= ra_q;
      cursor      <= cur_c;
      frame_start <= fs_c;

      // A new match restarts the pulse width.
      if (hs_start) begin
        hs_rem_q <= hs_width_m1;
      end else if (hs_rem_q != 4'd0) begin
        hs_rem_q <= hs_rem_q - 4'd1;
      end

      row_start_q <= row_start_d;

      if (h_end) begin
        h_cnt_q <= '0;
        row_q   <= row_d;
        ra_q    <= ra_d;
        state_q <= state_d;
        if (vs_start) begin
          vs_rem_q <= vs_width_m1;
        end else if (vs_rem_q != 4'd0) begin
          vs_rem_q <= vs_rem_q - 4'd1;
        end
        if (frame_wrap) begin
          ma_q        <= start_addr;
          row_start_q <= start_addr;
          frame_cnt_q <= frame_cnt_q + 6'd1;
        end else begin
          ma_q <= row_start_d;
        end
      end else begin
        h_cnt_q <= h_cnt_q + 1'b1;
        ma_q    <= ma_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/crtc_timing.md
# crtc_timing

Programmable, register-driven CRT controller timing core with parametrised counter widths. It generates horizontal/vertical sync, display enable, refresh memory address, raster address and cursor from a 6845-style register file, including the vertical total adjust, start address and cursor functions the fixed-timing generator lacks. It sits between the CPU bus (register port) and the dot/character fetch logic, and runs on a single clock with a character-rate enable.

## Interface
- H_WIDTH, 8: horizontal character counter and R0–R2 width.
- V_WIDTH, 7: row counter and R4/R6/R7 width.
- RA_WIDTH, 5: raster (scanline-in-row) counter width.
- MA_WIDTH, 14: refresh memory address width.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- char_ce  in  1  character clock enable; all timing advances only on clk edges with char_ce=1.
- reg_we  in  1  register write strobe, sampled every clk.
- reg_addr  in  5  register index 0–17.
- reg_wdata  in  8  write data.
- reg_rdata  out  8  read data for reg_addr; combinational.
- h_sync  out  1  horizontal sync, active-high.
- v_sync  out  1  vertical sync, active-high.
- de  out  1  display enable (h and v active, not in adjust).
- ma  out  MA_WIDTH  refresh memory address.
- ra  out  RA_WIDTH  raster address.
- cursor  out  1  cursor pixel-row active.
- frame_start  out  1  one-char pulse at h=0, row=0, raster=0.

## Operation
- Registers: R0 h_total−1, R1 h_displayed, R2 hsync_pos, R3[3:0] hsync width (0=16), R3[7:4] vsync width in lines (0=16), R4 v_total−1 (rows), R5[4:0] v_adjust lines, R6 v_displayed, R7 vsync_pos (row), R9 max_raster, R10[4:0] cursor start raster, R10[6:5] blink mode, R11 cursor end raster, R12/R13 start address hi/lo, R14/R15 cursor address hi/lo. R8, R16, R17 write-ignored.
- Reset defaults: R0=63, R1=40, R2=48, R3=0x15, R4=32, R5=0, R6=25, R7=28, R9=7, R10=0x20, R11=0, R12=0x10, R13..R15=0.
- reg_rdata: R14, R15 readable; R16, R17 and others read 0.
- Horizontal: h_cnt 0..R0, wraps to 0. End-of-line when h_cnt==R0 or h_cnt all-ones (guards a shrunken R0).
- Vertical: on end-of-line ra increments; at ra==R9, ra=0 and row increments. At row==R4 && ra==R9: if R5==0, next line is frame start; else enter ADJUST for R5 lines (ra counts 0..R5−1), then frame start.
- States: ACTIVE_V (row<R6), BLANK_V (row≥R6), ADJUST. de = h_cnt<R1 && state==ACTIVE_V.
- h_sync rises at h_cnt==R2 and holds for the R3[3:0] width in characters; a new R2 match during a pulse restarts the width count. v_sync rises at the line start of row==R7, ra==0 and holds for the R3[7:4] width in lines.
- ma: at frame start, ma = {R12,R13} truncated to MA_WIDTH. Increments each char. At end-of-line, ma reloads row_start. When h_cnt==R1 on ra==R9, row_start latches the current ma. Wraps mod 2^MA_WIDTH.
- cursor = de && ma=={R14,R15} && R10[4:0]≤ra≤R11 && blink gate. Blink modes: 00 on, 01 off, 10 toggles every 16 frames, 11 every 32 frames. A 6-bit frame counter increments at each frame start.
- Register writes apply on the clk edge of reg_we and are used from the next char_ce onward. Writes are permitted mid-frame.

## Timing
- All outputs are registered and update only on clk edges with char_ce=1. They reflect the counter values of that same character, with zero character latency between ma/ra and de/cursor.
- Reset: h_cnt=row=ra=0, ma={R12,R13} default (0x1000 & mask), state ACTIVE_V. Outputs after reset: h_sync=v_sync=de=cursor=frame_start=0, ma=0, ra=0, until the first char_ce. Reset mid-frame aborts immediately.
- Line period = R0+1 chars. Frame = (R4+1)(R9+1)+R5 lines.
- Degenerate settings: R1>R0 gives de for the whole line; R2>R0 gives no h_sync; R7>R4 gives no v_sync.

## Test plan
- Defaults, char_ce every clk: line = 64 chars; de high for h 0..39; h_sync high for h 48..52; frame = 33×8 = 264 lines; v_sync lines 224..224+(width 1).
- R5=3: frame = 267 lines; de=0 and v_sync=0 during the 3 adjust lines; ra counts 0..2 there.
- R12:R13=0x3FF0, R1=40: ma wraps 0x3FFF→0x0000 mid-row; second row starts at 0x0018.
- R14:R15=0x0005, R10=0x42, R11=5, blink mode 10: cursor high at ma=5 for ra 2..5 only, on for 16 frames then off for 16.
- R3=0x00: h_sync width 16 chars, v_sync width 16 lines.
- Write R0=20 while h_cnt=30: h_cnt runs to 255 then wraps; next line is 21 chars. Assert reset at h=10, row=3: all outputs go 0 immediately and restart at frame start.
